nmi_arbiter: RTL

Two-master arbiter sharing one native memory interface (NMI) slave port between the CPU core (master 0) and the DMA engine (master 1), placed at the master side of the system bus. It uses fixed priority to the core, with a wait counter so the DMA is not starved. It also has a slave-response timeout that completes a hung transfer with a fixed read value and records a sticky error.

---
 rtl/nmi_arbiter_if.sv | 47 ++++
 rtl/nmi_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/nmi_arbiter_if.sv
// Native memory interface bundle between the two masters (core = m0,
// DMA = m1), the arbiter and the shared bus slave port.
// master: the arbiter's view (forwards requests onto the bus).
// slave : the environment's view (masters plus bus slave).
interface nmi_arbiter_if;
   logic        m0_valid_i;
   logic        m0_instr_i;
   logic [31:0] m0_addr_i;
   logic [31:0] m0_wdata_i;
   logic [3:0]  m0_wstrb_i;
   logic        m0_ready_o;
   logic [31:0] m0_rdata_o;

   logic        m1_valid_i;
   logic        m1_instr_i;
   logic [31:0] m1_addr_i;
   logic [31:0] m1_wdata_i;
   logic [3:0]  m1_wstrb_i;
   logic        m1_ready_o;
   logic [31:0] m1_rdata_o;

   logic        s_valid_o;
   logic        s_instr_o;
   logic [31:0] s_addr_o;
   logic [31:0] s_wdata_o;
   logic [3:0]  s_wstrb_o;
   logic        s_ready_i;
   logic [31:0] s_rdata_i;

   modport master (
      input  m0_valid_i, m0_instr_i, m0_addr_i, m0_wdata_i, m0_wstrb_i,
      output m0_ready_o, m0_rdata_o,
      input  m1_valid_i, m1_instr_i, m1_addr_i, m1_wdata_i, m1_wstrb_i,
      output m1_ready_o, m1_rdata_o,
      output s_valid_o, s_instr_o, s_addr_o, s_wdata_o, s_wstrb_o,
      input  s_ready_i, s_rdata_i
   );

   modport slave (
      output m0_valid_i, m0_instr_i, m0_addr_i, m0_wdata_i, m0_wstrb_i,
      input  m0_ready_o, m0_rdata_o,
      output m1_valid_i, m1_instr_i, m1_addr_i, m1_wdata_i, m1_wstrb_i,
      input  m1_ready_o, m1_rdata_o,
      input  s_valid_o, s_instr_o, s_addr_o, s_wdata_o, s_wstrb_o,
      output s_ready_i, s_rdata_i
   );
endinterface

// File: rtl/nmi_arbiter.sv
// Two-master NMI arbiter: fixed priority to the core (m0), with a DMA (m1)
// wait counter that overrides priority once the DMA has waited MAX_WAIT
// cycles, and a slave-response timeout that force-completes a hung transfer
// with TMO_RDATA and records a sticky error.
module nmi_arbiter #(
   parameter int unsigned MAX_WAIT  = 16,
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [31:0] TMO_RDATA = 32'hDEAD_BEEF
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   nmi_arbiter_if.master bus,
   input  logic          err_clr_i,
   output logic          err_o,
   output logic          err_id_o,
   output logic [31:0]   err_addr_o
);

   // Counter widths fall back to one bit when the feature is disabled.
   localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [WW-1:0] wait_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          granted;
   logic          tmo_fire;
   logic          done;
   logic          dma_first;
   logic [31:0]   gnt_addr;

   assign granted   = (state != IDLE);
   assign tmo_fire  = (TIMEOUT != 0) && granted && !bus.s_ready_i && (tmo_cnt == TMO_LAST);
   assign done      = granted && (bus.s_ready_i || tmo_fire);
   assign dma_first = (MAX_WAIT != 0) && (wait_cnt >= WAIT_MAX);
   assign gnt_addr  = (state == GNT1) ? bus.m1_addr_i : bus.m0_addr_i;

   // Next-state: arbitrate in IDLE, hold the grant until completion or timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.m0_valid_i && bus.m1_valid_i) state_nxt = dma_first ? GNT1 : GNT0;
            else if (bus.m0_valid_i)              state_nxt = GNT0;
            else if (bus.m1_valid_i)              state_nxt = GNT1;
         end
         GNT0, GNT1: if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Forward the granted master to the bus and route the response back.
   always_comb begin
      bus.s_valid_o  = 1'b0;
      bus.s_instr_o  = 1'b0;
      bus.s_addr_o   = '0;
      bus.s_wdata_o  = '0;
      bus.s_wstrb_o  = '0;
      bus.m0_ready_o = 1'b0;
      bus.m0_rdata_o = '0;
      bus.m1_ready_o = 1'b0;
      bus.m1_rdata_o = '0;
      case (state)
         GNT0: begin
            bus.s_valid_o  = bus.m0_valid_i;
            bus.s_instr_o  = bus.m0_instr_i;
            bus.s_addr_o   = bus.m0_addr_i;
            bus.s_wdata_o  = bus.m0_wdata_i;
            bus.s_wstrb_o  = bus.m0_wstrb_i;
            bus.m0_ready_o = bus.s_ready_i | tmo_fire;
            bus.m0_rdata_o = tmo_fire ? TMO_RDATA : bus.s_rdata_i;
         end
         GNT1: begin
            bus.s_valid_o  = bus.m1_valid_i;
            bus.s_instr_o  = bus.m1_instr_i;
            bus.s_addr_o   = bus.m1_addr_i;
            bus.s_wdata_o  = bus.m1_wdata_i;
            bus.s_wstrb_o  = bus.m1_wstrb_i;
            bus.m1_ready_o = bus.s_ready_i | tmo_fire;
            bus.m1_rdata_o = tmo_fire ? TMO_RDATA : bus.s_rdata_i;
         end
         default: ;
      endcase
   end

   // State, DMA wait counter, timeout counter and sticky error capture.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         tmo_cnt    <= '0;
         err_o      <= 1'b0;
         err_id_o   <= 1'b0;
         err_addr_o <= '0;
      end else begin
         state <= state_nxt;

         if (MAX_WAIT != 0) begin
            if (state == IDLE && state_nxt == GNT1)
               wait_cnt <= '0;
            else if (bus.m1_valid_i && state != GNT1 && wait_cnt != WAIT_MAX)
               wait_cnt <= wait_cnt + 1'b1;
         end

         if (state == IDLE)
            tmo_cnt <= '0;
         else if (!bus.s_ready_i && TIMEOUT != 0)
            tmo_cnt <= tmo_cnt + 1'b1;

         // A capture takes precedence over a coincident clear.
         if (tmo_fire) begin
            err_o      <= 1'b1;
            err_id_o   <= (state == GNT1);
            err_addr_o <= gnt_addr;
         end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_id_o   <= 1'b0;
            err_addr_o <= '0;
         end
      end
   end

endmodule
